// File: rtl/axi_pkg.sv
// axi_pkg: AXI widths, response/burst constants and slave FSM states
package axi_pkg;
   localparam int AXI_IDS_BITS  = 8;
   localparam int AXI_ADDR_BITS = 32;
   localparam int AXI_LEN_BITS  = 4;
   localparam int AXI_SIZE_BITS = 3;
   localparam int AXI_DATA_BITS = 32;
   localparam int AXI_STRB_BITS = 4;
   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;
   localparam logic [1:0] AXI_INCR   = 2'b01;
   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} axi_slv_state_e;
endpackage

// File: rtl/sram_axi_slave.sv
// sram_axi_slave: AXI4 INCR burst slave mapped onto a single-port SRAM with 1-cycle read latency
module sram_axi_slave
   import axi_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AXI_IDS_BITS-1:0]  ARID,
   input  logic [AXI_ADDR_BITS-1:0] ARADDR,
   input  logic [AXI_LEN_BITS-1:0]  ARLEN,
   input  logic [AXI_SIZE_BITS-1:0] ARSIZE,
   input  logic [1:0]               ARBURST,
   input  logic                     ARVALID,
   output logic                     ARREADY,
   output logic [AXI_IDS_BITS-1:0]  RID,
   output logic [AXI_DATA_BITS-1:0] RDATA,
   output logic [1:0]               RRESP,
   output logic                     RLAST,
   output logic                     RVALID,
   input  logic                     RREADY,
   input  logic [AXI_IDS_BITS-1:0]  AWID,
   input  logic [AXI_ADDR_BITS-1:0] AWADDR,
   input  logic [AXI_LEN_BITS-1:0]  AWLEN,
   input  logic [AXI_SIZE_BITS-1:0] AWSIZE,
   input  logic [1:0]               AWBURST,
   input  logic                     AWVALID,
   output logic                     AWREADY,
   input  logic [AXI_DATA_BITS-1:0] WDATA,
   input  logic [AXI_STRB_BITS-1:0] WSTRB,
   input  logic                     WLAST,
   input  logic                     WVALID,
   output logic                     WREADY,
   output logic [AXI_IDS_BITS-1:0]  BID,
   output logic [1:0]               BRESP,
   output logic                     BVALID,
   input  logic                     BREADY,
   output logic                     sram_CEB,
   output logic                     sram_WEB,
   output logic [31:0]              sram_BWEB,
   output logic [ADDR_W-1:0]        sram_A,
   output logic [31:0]              sram_DI,
   input  logic [31:0]              sram_DO
);
   axi_slv_state_e           state;
   logic [AXI_IDS_BITS-1:0]  id_q;
   logic [AXI_LEN_BITS-1:0]  len_q;
   logic [3:0]               cnt;
   logic [ADDR_W-1:0]        addr_q;
   logic                     err;
   logic                     last, ar_hs, aw_hs, rd_adv, w_beat;
   logic                     unused_bits;

   assign last   = cnt == len_q;
   // Handshakes and SRAM accesses are suppressed while reset is held so nothing is half-accepted.
   assign ar_hs  = ~rst & (state == IDLE) & ARVALID;
   assign aw_hs  = ~rst & (state == IDLE) & AWVALID & ~ARVALID;
   assign rd_adv = ~rst & (state == RD) & RREADY & ~last;
   assign w_beat = ~rst & (state == WR) & WVALID;

   assign ARREADY = ar_hs;
   assign AWREADY = aw_hs;
   assign RVALID  = state == RD;
   assign RLAST   = RVALID & last;
   assign RDATA   = RVALID ? sram_DO : '0;
   assign RID     = id_q;
   assign RRESP   = AXI_OKAY;
   assign WREADY  = state == WR;
   assign BVALID  = state == WRESP;
   assign BID     = id_q;
   assign BRESP   = (BVALID & err) ? AXI_SLVERR : AXI_OKAY;

   // Reads prefetch the next word only when the current beat is consumed, so stalls keep sram_DO stable.
   assign sram_CEB  = ~(ar_hs | rd_adv | w_beat);
   assign sram_WEB  = ~w_beat;
   assign sram_BWEB = w_beat ? ~{{8{WSTRB[3]}}, {8{WSTRB[2]}}, {8{WSTRB[1]}}, {8{WSTRB[0]}}} : '1;
   assign sram_DI   = w_beat ? WDATA : '0;
   assign sram_A    = w_beat ? addr_q + ADDR_W'(cnt) :
                      rd_adv ? addr_q + ADDR_W'(cnt) + ADDR_W'(1) :
                      ar_hs  ? ARADDR[ADDR_W+1:2] : '0;

   assign unused_bits = ^{ARSIZE, ARBURST, AWSIZE, AWBURST, ARADDR[AXI_ADDR_BITS-1:ADDR_W+2],
                          ARADDR[1:0], AWADDR[AXI_ADDR_BITS-1:ADDR_W+2], AWADDR[1:0]};

   // Transaction FSM: latch the address phase, count beats, track WLAST/LEN disagreement.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         id_q   <= '0;
         len_q  <= '0;
         cnt    <= '0;
         addr_q <= '0;
         err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (ar_hs) begin
                  id_q   <= ARID;
                  len_q  <= ARLEN;
                  addr_q <= ARADDR[ADDR_W+1:2];
                  state  <= RD;
               end else if (aw_hs) begin
                  id_q   <= AWID;
                  len_q  <= AWLEN;
                  addr_q <= AWADDR[ADDR_W+1:2];
                  state  <= WR;
               end
            end
            RD: if (RREADY) begin
               if (last) state <= IDLE;
               else cnt <= cnt + 4'd1;
            end
            WR: if (WVALID) begin
               cnt <= cnt + 4'd1;
               if (WLAST != last) err <= 1'b1;
               if (last) state <= WRESP;
            end
            WRESP: if (BREADY) begin
               state <= IDLE;
               err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_axi_slave.sv
// tb_sram_axi_slave: table vectors, directed corner sequences and random bursts against a word-array reference
module tb_sram_axi_slave;
   import axi_pkg::*;
   localparam int ADDR_W = 14;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst;
   logic [7:0]  ARID, AWID, RID, BID;
   logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
   logic [3:0]  ARLEN, AWLEN, WSTRB;
   logic [2:0]  ARSIZE, AWSIZE;
   logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
   logic ARVALID, ARREADY, RLAST, RVALID, RREADY, AWVALID, AWREADY;
   logic WLAST, WVALID, WREADY, BVALID, BREADY;
   logic sram_CEB, sram_WEB;
   logic [31:0] sram_BWEB, sram_DI;
   logic [31:0] sram_DO = '0;
   logic [ADDR_W-1:0] sram_A;

   always #5 clk = ~clk;

   sram_axi_slave #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .sram_CEB(sram_CEB), .sram_WEB(sram_WEB), .sram_BWEB(sram_BWEB), .sram_A(sram_A),
      .sram_DI(sram_DI), .sram_DO(sram_DO)
   );

   // SRAM macro model plus a log of every write and a count of every read access
   typedef struct {logic [ADDR_W-1:0] a; logic [31:0] d; logic [31:0] bweb;} wr_t;
   logic [31:0] mem [DEPTH];
   wr_t wlog[$];
   int rd_cnt = 0;

   initial for (int i = 0; i < DEPTH; i++) mem[i] <= '0;

   always @(posedge clk) begin
      if (!sram_CEB) begin
         if (!sram_WEB) begin
            mem[sram_A] <= (mem[sram_A] & sram_BWEB) | (sram_DI & ~sram_BWEB);
            wlog.push_back('{sram_A, sram_DI, sram_BWEB});
         end else begin
            sram_DO <= mem[sram_A];
            rd_cnt++;
         end
      end
   end

   // Reference memory: transaction-level view of what every word should hold
   logic [31:0] ref_mem [DEPTH];
   int n_pass = 0, n_tot = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [31:0] bweb_of(input logic [3:0] s);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? 8'h00 : 8'hFF;
      return r;
   endfunction

   function automatic int word_of(input logic [31:0] addr, input int beat);
      return (int'(addr >> 2) + beat) % DEPTH;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_arready"}, ARREADY, 0);
      chk({tag, "_awready"}, AWREADY, 0);
      chk({tag, "_rvalid"}, RVALID, 0);
      chk({tag, "_rlast"}, RLAST, 0);
      chk({tag, "_rdata"}, RDATA, 0);
      chk({tag, "_rid"}, RID, 0);
      chk({tag, "_rresp"}, RRESP, 0);
      chk({tag, "_wready"}, WREADY, 0);
      chk({tag, "_bvalid"}, BVALID, 0);
      chk({tag, "_bid"}, BID, 0);
      chk({tag, "_bresp"}, BRESP, 0);
      chk({tag, "_ceb"}, sram_CEB, 1);
      chk({tag, "_web"}, sram_WEB, 1);
      chk({tag, "_bweb"}, sram_BWEB, 32'hFFFF_FFFF);
   endtask

   task automatic aw_req(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
      int k = 0;
      @(negedge clk);
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = AXI_INCR; AWVALID = 1'b1;
      #1;
      while (!AWREADY && k < 50) begin @(negedge clk); #1; k++; end
      if (!AWREADY) chk("aw_timeout", AWREADY, 1);
      @(posedge clk); #1;
      AWVALID = 1'b0;
   endtask

   task automatic w_data(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [31:0] d [16], input logic [3:0] s [16], input int lastb,
                         input bit gaps);
      int k;
      wlog.delete();
      for (int i = 0; i <= int'(len); i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin @(negedge clk); WVALID = 1'b0; end
         @(negedge clk);
         WVALID = 1'b1; WDATA = d[i]; WSTRB = s[i]; WLAST = (i == lastb);
         #1; k = 0;
         while (!WREADY && k < 50) begin @(negedge clk); #1; k++; end
         if (!WREADY) chk("w_timeout", WREADY, 1);
         @(posedge clk);
      end
      @(negedge clk);
      WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
      #1; k = 0;
      while (!BVALID && k < 50) begin @(negedge clk); #1; k++; end
      chk("b_valid", BVALID, 1);
      chk("b_id", BID, id);
      chk("b_resp", BRESP, (lastb == int'(len)) ? AXI_OKAY : AXI_SLVERR);
      @(posedge clk); #1;
      BREADY = 1'b0;
      chk("wr_beats", wlog.size(), int'(len) + 1);
      for (int i = 0; i <= int'(len); i++) begin
         if (i < wlog.size()) begin
            chk("wr_addr", 32'(wlog[i].a), word_of(addr, i));
            chk("wr_data", wlog[i].d, d[i]);
            chk("wr_bweb", wlog[i].bweb, bweb_of(s[i]));
         end
         for (int b = 0; b < 4; b++)
            if (s[i][b]) ref_mem[word_of(addr, i)][8*b +: 8] = d[i][8*b +: 8];
      end
   endtask

   task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] d [16], input logic [3:0] s [16], input int lastb,
                           input bit gaps);
      aw_req(id, addr, len);
      w_data(id, addr, len, d, s, lastb, gaps);
   endtask

   task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [15:0] pat, output logic [31:0] last_data);
      int k = 0, beat = 0, rd0;
      bit stalled = 0;
      logic [31:0] prev = '0;
      last_data = '0;
      @(negedge clk);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = AXI_INCR; ARVALID = 1'b1;
      RREADY = 1'b0;
      #1;
      while (!ARREADY && k < 50) begin @(negedge clk); #1; k++; end
      if (!ARREADY) chk("ar_timeout", ARREADY, 1);
      rd0 = rd_cnt;
      @(posedge clk); #1;
      ARVALID = 1'b0;
      @(negedge clk);
      k = 0;
      while (beat <= int'(len) && k < 400) begin
         RREADY = pat[k % 16];
         #1;
         if (k == 0) chk("r_first_valid", RVALID, 1);
         if (stalled) chk("r_hold", RDATA, prev);
         if (RVALID && RREADY) begin
            chk("r_data", RDATA, ref_mem[word_of(addr, beat)]);
            chk("r_last", RLAST, beat == int'(len));
            chk("r_id", RID, id);
            chk("r_resp", RRESP, AXI_OKAY);
            last_data = RDATA;
            beat++;
         end
         stalled = RVALID && !RREADY;
         prev = RDATA;
         k++;
         @(negedge clk);
      end
      RREADY = 1'b0;
      #1;
      chk("r_beats", beat, int'(len) + 1);
      chk("r_valid_drop", RVALID, 0);
      chk("r_sram_reads", rd_cnt - rd0, int'(len) + 1);
      if (pat == 16'hFFFF) chk("r_no_bubble", k, int'(len) + 1);
   endtask

   typedef struct {
      logic [31:0] addr; logic [31:0] prev; logic [3:0] strb;
      logic [31:0] data; logic [31:0] bweb; logic [31:0] rb;
   } vec_t;
   vec_t tbl [7];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] d [16];
      logic [3:0]  s [16];
      logic [31:0] rdl;
      int beats, k, lastb;
      bit acc;
      logic [31:0] addr;
      logic [3:0]  len;

      tbl[0] = '{32'h0000_0010, 32'h0000_00A0, 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_00FF, 32'h0000_FFA0};
      tbl[1] = '{32'h0000_0020, 32'h1234_5678, 4'b0001, 32'hAABB_CCDD, 32'hFFFF_FF00, 32'h1234_56DD};
      tbl[2] = '{32'h0000_0024, 32'h1234_5678, 4'b1000, 32'hAABB_CCDD, 32'h00FF_FFFF, 32'hAA34_5678};
      tbl[3] = '{32'h0000_0028, 32'h0000_0000, 4'b0101, 32'hFFFF_FFFF, 32'hFF00_FF00, 32'h00FF_00FF};
      tbl[4] = '{32'h0000_002C, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tbl[5] = '{32'h0000_FFFC, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF};
      tbl[6] = '{32'h0001_0031, 32'h5555_5555, 4'b0110, 32'h0BAD_F00D, 32'hFF00_00FF, 32'h55AD_F055};

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      for (int i = 0; i < 16; i++) begin d[i] = '0; s[i] = 4'hF; end
      ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
      AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
      WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk_reset_outputs("reset");
      rst = 1'b0;

      // 4-beat write to words 4..7, then full-speed and stalled readback
      for (int i = 0; i < 4; i++) d[i] = 32'hA0 + i;
      do_write(8'h3, 32'h10, 4'd3, d, s, 3, 0);
      do_read(8'h7, 32'h10, 4'd3, 16'hFFFF, rdl);
      chk("rd_last_word", rdl, 32'hA3);
      do_read(8'h8, 32'h10, 4'd3, 16'h9999, rdl);

      // Strobe table: seed a word, partially overwrite it, read it back
      foreach (tbl[t]) begin
         d[0] = tbl[t].prev; s[0] = 4'hF;
         do_write(8'h1, tbl[t].addr, 4'd0, d, s, 0, 0);
         d[0] = tbl[t].data; s[0] = tbl[t].strb;
         do_write(8'h2, tbl[t].addr, 4'd0, d, s, 0, 0);
         if (wlog.size() > 0) chk("tbl_bweb", wlog[0].bweb, tbl[t].bweb);
         do_read(8'h4, tbl[t].addr, 4'd0, 16'hFFFF, rdl);
         chk("tbl_rdata", rdl, tbl[t].rb);
      end
      s[0] = 4'hF;

      // Simultaneous AR and AW: read wins, write waits until RLAST completes
      @(negedge clk);
      ARID = 8'h5; ARADDR = 32'h10; ARLEN = 4'd1; ARVALID = 1'b1;
      AWID = 8'h6; AWADDR = 32'h40; AWLEN = 4'd0; AWVALID = 1'b1;
      RREADY = 1'b1;
      #1;
      chk("both_arready", ARREADY, 1);
      chk("both_awready", AWREADY, 0);
      @(posedge clk); #1;
      ARVALID = 1'b0;
      beats = 0; k = 0; acc = 0;
      while (!acc && k < 20) begin
         @(negedge clk); #1;
         if (RVALID) chk("aw_blocked", AWREADY, 0);
         if (RVALID && RREADY) begin
            chk("both_rdata", RDATA, ref_mem[4 + beats]);
            beats++;
         end
         if (AWREADY) begin
            chk("aw_after_rlast", beats, 2);
            acc = 1;
         end
         k++;
      end
      if (!acc) chk("aw_accept", 0, 1);
      @(posedge clk); #1;
      AWVALID = 1'b0; RREADY = 1'b0;
      d[0] = 32'hCAFE_0040;
      w_data(8'h6, 32'h40, 4'd0, d, s, 0, 0);
      do_read(8'h9, 32'h40, 4'd0, 16'hFFFF, rdl);
      chk("deferred_write", rdl, 32'hCAFE_0040);

      // Early WLAST: LEN governs termination, response is SLVERR
      for (int i = 0; i < 4; i++) d[i] = 32'hB0 + i;
      do_write(8'h9, 32'h80, 4'd3, d, s, 2, 0);
      do_read(8'hA, 32'h80, 4'd3, 16'hFFFF, rdl);
      chk("early_wlast_word3", rdl, 32'hB3);

      // Reset in the middle of a read burst
      @(negedge clk);
      ARID = 8'hC; ARADDR = 32'h80; ARLEN = 4'd3; ARVALID = 1'b1; RREADY = 1'b1;
      @(posedge clk); #1;
      ARVALID = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      chk_reset_outputs("midrst");
      rst = 1'b0; RREADY = 1'b0;
      do_read(8'hD, 32'h80, 4'd3, 16'hFFFF, rdl);
      chk("post_rst_word3", rdl, 32'hB3);

      // Wrap across the top of the word space
      for (int i = 0; i < 4; i++) d[i] = 32'hE0 + i;
      do_write(8'h2, 32'h0000_FFF8, 4'd3, d, s, 3, 0);
      do_read(8'h3, 32'h0000_FFF8, 4'd3, 16'hFFFF, rdl);
      chk("wrap_word1", rdl, 32'hE3);

      // Random bursts against the reference memory
      for (int it = 0; it < 40; it++) begin
         k = $urandom_range(0, 1) ? $urandom_range(0, 63) : DEPTH - 8 + $urandom_range(0, 7);
         addr = (32'(k) << 2) | (32'($urandom_range(0, 3)) << (ADDR_W + 2)) | 32'($urandom_range(0, 3));
         len = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1)) begin
            for (int i = 0; i < 16; i++) begin d[i] = $urandom; s[i] = 4'($urandom); end
            lastb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : int'(len);
            do_write(8'($urandom), addr, len, d, s, lastb, 1);
         end else begin
            do_read(8'($urandom), addr, len, 16'($urandom) | 16'h1, rdl);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
